led_blink_driver: RTL
=====================

// Module: led_blink_driver
// PURPOSE
//  Consumes the 3-bit LED PIO output (led_req) and drives the board LEDs with per-LED modes:
//  follow, blink, one-shot pulse stretch, or force-off, plus global PWM dimming.
//  Own Avalon-MM slave (zero-wait read, PIO style) holds mode/period/duty; sits between PIO and pins.
// PARAMETERS
//  NUM_LEDS        3           number of LED channels (matches PIO width)
//  PRESCALE_W      24          width of tick prescaler / PERIOD register
//  DEFAULT_PERIOD  12_500_000  reset value of PERIOD (clk cycles per tick; 0.25 s @ 50 MHz)
//  PULSE_TICKS     4           pulse-stretch length in ticks for mode PULSE
// PORTS
//  clk         in   1            system clock
//  reset       in   1            synchronous, active-high reset
//  address     in   2            register select
//  chipselect  in   1            slave select
//  write_n     in   1            active-low write strobe
//  writedata   in   32           write data
//  readdata    out  32           read data, combinational from address, unused bits 0
//  led_req     in   NUM_LEDS     per-LED request from PIO, same clock domain
//  led_out     out  NUM_LEDS     registered LED drive, active-high
// BEHAVIOUR
//  Regs: 0 MODE[2*NUM_LEDS-1:0] (2b/LED, LED i at [2i+1:2i]); 1 PERIOD[PRESCALE_W-1:0];
//   2 DUTY[7:0]; 3 STATUS (RO, = led_out). Write when chipselect & ~write_n; writes to 3 ignored.
//  Reset: MODE=0, PERIOD=DEFAULT_PERIOD, DUTY=8'hFF, led_out=0, prescaler=PERIOD, phase=0, pulse cnts=0, req_d=0.
//  Tick: prescaler counts down; at 0 asserts tick one cycle and reloads PERIOD. PERIOD=0 treated as 1 (tick every cycle).
//   Write to PERIOD reloads prescaler with new value the next cycle; a tick coinciding with that write is suppressed.
//  Blink phase: one shared bit, toggles on each tick.
//  Pulse: req_d registers led_req; rise = led_req & ~req_d. On rise, LED's pulse cnt loads PULSE_TICKS;
//   decrements per tick while nonzero; rise during count reloads (retrigger); rise+tick same cycle -> load wins.
//  Modes: 00 FOLLOW  raw = led_req[i]
//         01 BLINK   raw = led_req[i] & phase
//         10 PULSE   raw = (pulse_cnt[i] != 0)
//         11 OFF     raw = 0
//  PWM: 8-bit free-running counter; pwm_on = (pwm_cnt < DUTY) | (DUTY == 8'hFF). DUTY=0 -> always off.
//  led_out[i] <= raw[i] & pwm_on  (1-cycle latency led_req -> led_out in FOLLOW, DUTY=FF).
//  MODE write takes effect on the cycle after the write; pulse counters keep running across mode changes.
//  Reset mid-operation: all state returns to reset values on the next edge; led_out low that edge.
// CONFIGURATION
//  LED_BLINK_DRIVER_PWM_EN defined: PWM counter and DUTY register present as above.
//  Not defined: no PWM counter, pwm_on tied 1, DUTY reads 0 and writes are ignored.
// STRUCTURE
//  led_drv_pkg: mode codes (MODE_FOLLOW/BLINK/PULSE/OFF), register addresses (REG_MODE/PERIOD/DUTY/STATUS),
//   DUTY reset constant.
//  Sub-module led_drv_tick_gen: prescaler + reload-on-write + tick output (PRESCALE_W parameter).
//  Top: register file, readdata mux, phase bit, per-LED pulse counters (generate loop), PWM, output regs.
// TESTING
//  1 Reset, MODE=0, DUTY=FF, led_req=3'b101 -> led_out=3'b101 exactly one cycle later; STATUS reads 5.
//  2 PERIOD=4, MODE LED0=BLINK, led_req[0]=1 -> led_out[0] toggles every 4 cycles; PERIOD=0 -> toggles every cycle.
//  3 PERIOD=2, MODE LED1=PULSE, 1-cycle pulse on led_req[1] -> led_out[1] high ~8 cycles (4 ticks);
//    second rise at tick 2 -> window restarts from 4.
//  4 PWM_EN, DUTY=64, FOLLOW, led_req=7 -> each LED high 64 of every 256 cycles; DUTY=0 -> constant 0;
//    DUTY=FF -> constant 1.
//  5 MODE=6'b111111 with led_req=7 -> led_out=0; write addr 3 -> no register change; read addr 1 -> PERIOD zero-extended.
//  6 Assert reset mid-blink/pulse -> next edge led_out=0, MODE=0, PERIOD=DEFAULT_PERIOD, DUTY=FF.

Source files
------------

// File: rtl/led_drv_pkg.sv
// Shared definitions for the LED blink driver:
// mode codes, register map and reset constants.
package led_drv_pkg;

    typedef enum logic [1:0] {
        MODE_FOLLOW = 2'b00,
        MODE_BLINK  = 2'b01,
        MODE_PULSE  = 2'b10,
        MODE_OFF    = 2'b11
    } led_mode_e;

    localparam logic [1:0] REG_MODE   = 2'd0;
    localparam logic [1:0] REG_PERIOD = 2'd1;
    localparam logic [1:0] REG_DUTY   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam logic [7:0] DUTY_RST = 8'hFF;

endpackage

// File: rtl/led_drv_tick_gen.sv
// Tick prescaler: one tick every max(PERIOD,1) cycles.
// A PERIOD write reloads the count and masks a tick in that cycle.
module led_drv_tick_gen #(
    parameter int PRESCALE_W = 24,
    parameter logic [PRESCALE_W-1:0] RST_VAL = '1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [PRESCALE_W-1:0] period_i,
    input  logic                  load_i,
    input  logic [PRESCALE_W-1:0] load_val_i,
    output logic                  tick_o
);

    localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

    logic [PRESCALE_W-1:0] cnt_q, cnt_d;
    logic                  at_end;

    // A period of zero behaves like one: tick every cycle.
    function automatic logic [PRESCALE_W-1:0] eff(
        input logic [PRESCALE_W-1:0] p
    );
        return (p == '0) ? ONE : p;
    endfunction

    // Count runs P..1, so the tick lands every P cycles.
    assign at_end = (cnt_q <= ONE);
    assign tick_o = at_end & ~load_i;

    // Next count: reload on write, reload on tick, else decrement.
    always_comb begin
        cnt_d = cnt_q - ONE;
        if (load_i) begin
            cnt_d = eff(load_val_i);
        end else if (at_end) begin
            cnt_d = eff(period_i);
        end
    end

    // Prescaler register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_blink_driver.sv
// LED driver between PIO and pins: follow/blink/pulse/off per LED.
// Optional PWM dimming enabled by defining LED_BLINK_DRIVER_PWM_EN.
module led_blink_driver
    import led_drv_pkg::*;
#(
    parameter int NUM_LEDS       = 3,
    parameter int PRESCALE_W     = 24,
    parameter int DEFAULT_PERIOD = 12_500_000,
    parameter int PULSE_TICKS    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          address,
    input  logic                chipselect,
    input  logic                write_n,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    input  logic [NUM_LEDS-1:0] led_req,
    output logic [NUM_LEDS-1:0] led_out
);

    localparam int MW = 2 * NUM_LEDS;
    localparam int PC_W = $clog2(PULSE_TICKS + 1);
    localparam logic [PC_W-1:0] PC_LOAD = PC_W'(PULSE_TICKS);
    localparam logic [PRESCALE_W-1:0] PERIOD_RST =
        PRESCALE_W'(DEFAULT_PERIOD);

    logic [MW-1:0]         mode_q, mode_d;
    logic [PRESCALE_W-1:0] period_q, period_d;
    logic                  phase_q, phase_d;
    logic [NUM_LEDS-1:0]   req_q;
    logic [NUM_LEDS-1:0]   led_q, led_d;
    logic [NUM_LEDS-1:0]   rise;
    logic [NUM_LEDS-1:0]   raw;
    logic [7:0]            duty_rd;
    logic                  pwm_on;
    logic                  tick;
    logic                  wr_en;
    logic                  wr_mode;
    logic                  wr_period;
    logic                  unused_wd;

    assign wr_en     = chipselect & ~write_n;
    assign wr_mode   = wr_en & (address == REG_MODE);
    assign wr_period = wr_en & (address == REG_PERIOD);
    assign unused_wd = ^writedata;

    led_drv_tick_gen #(
        .PRESCALE_W (PRESCALE_W),
        .RST_VAL    (PERIOD_RST)
    ) u_tick (
        .clk_i      (clk),
        .reset_i    (reset),
        .period_i   (period_q),
        .load_i     (wr_period),
        .load_val_i (writedata[PRESCALE_W-1:0]),
        .tick_o     (tick)
    );

    // Register file next state and shared blink phase.
    always_comb begin
        mode_d   = mode_q;
        period_d = period_q;
        phase_d  = phase_q ^ tick;
        if (wr_mode) begin
            mode_d = writedata[MW-1:0];
        end
        if (wr_period) begin
            period_d = writedata[PRESCALE_W-1:0];
        end
    end

    // Register file, phase and request history.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q   <= '0;
            period_q <= PERIOD_RST;
            phase_q  <= 1'b0;
            req_q    <= '0;
        end else begin
            mode_q   <= mode_d;
            period_q <= period_d;
            phase_q  <= phase_d;
            req_q    <= led_req;
        end
    end

    assign rise = led_req & ~req_q;

`ifdef LED_BLINK_DRIVER_PWM_EN
    logic [7:0] duty_q, duty_d;
    logic [7:0] pwm_q, pwm_d;
    logic       wr_duty;

    assign wr_duty = wr_en & (address == REG_DUTY);

    // Duty register update and free-running PWM counter.
    always_comb begin
        duty_d = duty_q;
        pwm_d  = pwm_q + 8'd1;
        if (wr_duty) begin
            duty_d = writedata[7:0];
        end
    end

    // Duty and PWM counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            duty_q <= DUTY_RST;
            pwm_q  <= '0;
        end else begin
            duty_q <= duty_d;
            pwm_q  <= pwm_d;
        end
    end

    assign pwm_on  = (pwm_q < duty_q) | (duty_q == 8'hFF);
    assign duty_rd = duty_q;
`else
    assign pwm_on  = 1'b1;
    assign duty_rd = 8'h00;
`endif

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_led
        logic [PC_W-1:0] pc_q, pc_d;
        logic            raw_b;
        led_mode_e       md;

        assign md = led_mode_e'(mode_q[2*i +: 2]);

        // Pulse stretch: a rising request (re)loads, ticks drain.
        always_comb begin
            pc_d = pc_q;
            if (rise[i]) begin
                pc_d = PC_LOAD;
            end else if (tick && (pc_q != '0)) begin
                pc_d = pc_q - PC_W'(1);
            end
        end

        // Pulse counter register.
        always_ff @(posedge clk) begin
            if (reset) begin
                pc_q <= '0;
            end else begin
                pc_q <= pc_d;
            end
        end

        // Per-LED mode select.
        always_comb begin
            raw_b = 1'b0;
            unique case (md)
                MODE_FOLLOW: raw_b = led_req[i];
                MODE_BLINK:  raw_b = led_req[i] & phase_q;
                MODE_PULSE:  raw_b = (pc_q != '0);
                MODE_OFF:    raw_b = 1'b0;
            endcase
        end

        assign raw[i] = raw_b;
    end

    assign led_d = raw & {NUM_LEDS{pwm_on}};

    // Registered LED drive.
    always_ff @(posedge clk) begin
        if (reset) begin
            led_q <= '0;
        end else begin
            led_q <= led_d;
        end
    end

    assign led_out = led_q;

    // Zero-wait read mux, unused bits zero.
    always_comb begin
        readdata = '0;
        unique case (address)
            REG_MODE:   readdata[MW-1:0] = mode_q;
            REG_PERIOD: readdata[PRESCALE_W-1:0] = period_q;
            REG_DUTY:   readdata[7:0] = duty_rd;
            REG_STATUS: readdata[NUM_LEDS-1:0] = led_q;
        endcase
    end

endmodule
